// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised line, mid-bit sampling,
// optional parity, 1-2 stop bits and a single-entry valid/ready output holding register.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | half-bit wait, then recheck the start bit
//   DATA      | sampling data bits, LSB first
//   PAR       | sampling the parity bit
//   STOP      | sampling stop bits, frame completes on the last one
//   WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module uart_rx_param #(
  parameter int CLK_FREQ  = 1000,
  parameter int BAUD_RATE = 10,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);
  localparam int IW      = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST      = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_MID       = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done;
  logic                 mid_bit;
  logic                 rx_meta, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    mid_bit = (cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IW'(i)) shift_d[i] = rx_s;
          end
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (mid_bit) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s) != (PARITY == 1);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (mid_bit) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_s;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d   = '0;
            done    = 1'b1;
            // a low stop bit may be the start of a break; wait it out
            state_d = ferr_d ? S_WAIT_HIGH : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_d;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default 8N1 receiver and an 8E2 receiver, each fed
// serial frames built from plain bit lists and checked against a frame queue.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BIT_CNT = 100;
  localparam int HALF    = BIT_CNT / 2;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] dout0, dout1;
  logic       v0, pe0, fe0, ovr0, busy0;
  logic       v1, pe1, fe1, ovr1, busy1;

  int total = 0;
  int bad   = 0;
  int vcyc0 = 0;
  int ovr_cnt0 = 0, ovr_cnt1 = 0;
  int exp_ovr0 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  uart_rx_param u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .data_ready(rdy0),
    .data_out(dout0), .data_valid(v0), .parity_err(pe0), .frame_err(fe0),
    .overrun_err(ovr0), .busy(busy0)
  );

  uart_rx_param #(.PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .data_ready(rdy1),
    .data_out(dout1), .data_valid(v1), .parity_err(pe1), .frame_err(fe1),
    .overrun_err(ovr1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (v0) vcyc0++;
    if (ovr0) ovr_cnt0++;
    if (ovr1) ovr_cnt1++;
    if (v0 && rdy0) begin
      chk("d0_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("d0_data", 32'(dout0), 32'(e0.d));
        chk("d0_perr", 32'(pe0), 32'(e0.pe));
        chk("d0_ferr", 32'(fe0), 32'(e0.fe));
      end
    end
    if (v1 && rdy1) begin
      chk("d1_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("d1_data", 32'(dout1), 32'(e1.d));
        chk("d1_perr", 32'(pe1), 32'(e1.pe));
        chk("d1_ferr", 32'(fe1), 32'(e1.fe));
      end
    end
  end

  task automatic drive(input int which, input logic b, input int n);
    if (which == 0) rx0 = b;
    else rx1 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame expectation is registered before the stop bits go out so it is queued
  // ahead of the receiver's completion.
  task automatic send_frame(input int which, input logic [7:0] data,
                            input logic par_bit, input logic [1:0] stops);
    exp_t e;
    e.d  = data;
    e.pe = (which == 1) ? (par_bit != (^data)) : 1'b0;
    e.fe = (which == 0) ? ~stops[0] : ~(stops[0] & stops[1]);
    drive(which, 1'b0, BIT_CNT);
    for (int i = 0; i < 8; i++) drive(which, data[i], BIT_CNT);
    if (which == 1) drive(which, par_bit, BIT_CNT);
    if (which == 0) begin
      if (q0.size() > 0 && !rdy0) exp_ovr0++;
      else q0.push_back(e);
      drive(0, stops[0], BIT_CNT);
    end else begin
      q1.push_back(e);
      drive(1, stops[0], BIT_CNT);
      drive(1, stops[1], BIT_CNT);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic [1:0] s;
    int         vb;

    rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_flags", 32'({pe0, fe0, ovr0}), 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b1, 5);

    // clean 8N1 frame, valid for exactly one cycle with ready high
    vcyc0 = 0;
    send_frame(0, 8'hA5, 1'b0, 2'b11);
    drive(0, 1'b1, 10);
    chk("a5_valid_cycles", 32'(vcyc0), 32'd1);
    chk("a5_dout", 32'(dout0), 32'hA5);
    chk("a5_pending", 32'(q0.size()), 32'd0);

    // even parity: 0x37 has five ones, so parity bit 1 is correct
    send_frame(1, 8'h37, 1'b0, 2'b11);
    drive(1, 1'b1, 10);
    chk("par37_bad", 32'(pe1), 32'd1);
    send_frame(1, 8'h37, 1'b1, 2'b11);
    drive(1, 1'b1, 10);
    chk("par37_good", 32'(pe1), 32'd0);
    chk("par37_dout", 32'(dout1), 32'h37);

    // break: low stop bit then line held low
    send_frame(0, 8'h3C, 1'b0, 2'b00);
    drive(0, 1'b0, 250);
    chk("brk_busy", 32'(busy0), 32'd1);
    drive(0, 1'b0, 250);
    chk("brk_frame_err", 32'(fe0), 32'd1);
    drive(0, 1'b1, 5);
    chk("brk_released", 32'(busy0), 32'd0);
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    drive(0, 1'b1, 10);
    chk("brk_pending", 32'(q0.size()), 32'd0);

    // short low glitch on the line
    vb = vcyc0;
    drive(0, 1'b0, 10);
    chk("glitch_busy", 32'(busy0), 32'd1);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, HALF + 3 - 20);
    chk("glitch_idle", 32'(busy0), 32'd0);
    drive(0, 1'b1, 60);
    chk("glitch_no_valid", 32'(vcyc0), 32'(vb));

    // overrun with consumer stalled
    rdy0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11);
    drive(0, 1'b1, 5);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    drive(0, 1'b1, 5);
    chk("ovr_hold_dout", 32'(dout0), 32'h11);
    chk("ovr_hold_valid", 32'(v0), 32'd1);
    chk("ovr_pulses", 32'(ovr_cnt0), 32'(exp_ovr0));
    rdy0 = 1'b1;
    drive(0, 1'b1, 2);
    chk("ovr_cleared", 32'(v0), 32'd0);
    chk("ovr_pending", 32'(q0.size()), 32'd0);

    // random 8N1 frames, occasional bad stop bit
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      s = {1'b1, 1'($urandom_range(0, 5) != 0)};
      send_frame(0, d, 1'b0, s);
      drive(0, 1'b1, 5 + $urandom_range(0, 20));
    end
    chk("rnd0_pending", 32'(q0.size()), 32'd0);

    // random 8E2 frames with random parity and stop bits
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      send_frame(1, d, p, s);
      drive(1, 1'b1, 5 + $urandom_range(0, 20));
    end
    chk("rnd1_pending", 32'(q1.size()), 32'd0);
    chk("rnd1_no_overrun", 32'(ovr_cnt1), 32'd0);

    // reset in the middle of the data bits, with a frame held
    rdy0 = 1'b0;
    send_frame(0, 8'h5F, 1'b0, 2'b11);
    drive(0, 1'b1, 5);
    drive(0, 1'b0, BIT_CNT);
    drive(0, 1'b1, BIT_CNT);
    drive(0, 1'b0, 40);
    chk("mid_busy", 32'(busy0), 32'd1);
    chk("mid_held", 32'(dout0), 32'h5F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(dout0), 32'd0);
    chk("mid_rst_valid", 32'(v0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_flags", 32'({pe0, fe0, ovr0}), 32'd0);
    q0.delete();
    drive(0, 1'b1, 5);
    rst_n = 1'b1;
    rdy0 = 1'b1;
    drive(0, 1'b1, 5);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    send_frame(0, 8'hC3, 1'b0, 2'b11);
    drive(0, 1'b1, 10);
    chk("c3_dout", 32'(dout0), 32'hC3);
    chk("final_pending0", 32'(q0.size()), 32'd0);
    chk("final_pending1", 32'(q1.size()), 32'd0);
    chk("final_overruns", 32'(ovr_cnt0), 32'(exp_ovr0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
